// File: rtl/lorenz_pkg.sv
// Shared types and constants for the Lorenz solver point streamer.
//   STATE_W/FRAC_W   : solver state format (signed 7.20)
//   SCREEN_W/SCREEN_H: target raster size in pixels
//   point_t          : one projected pixel plus its clamp flag
package lorenz_pkg;

   localparam int unsigned STATE_W  = 27;
   localparam int unsigned FRAC_W   = 20;
   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   localparam int unsigned PX_W     = 10;
   localparam int unsigned PY_W     = 9;
   // Projection arithmetic width: wide enough for shifted state plus offset
   localparam int unsigned PROJ_W   = 18;
   localparam int unsigned DEC_W    = 16;
   localparam int unsigned OVF_W    = 9;

   typedef struct packed {
      logic [PX_W-1:0] x;
      logic [PY_W-1:0] y;
      logic            clip;
   } point_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } stream_state_e;

   // True when a signed coordinate falls outside 0..hi
   function automatic logic out_of_range(input logic signed [PROJ_W-1:0] v,
                                         input logic signed [PROJ_W-1:0] hi);
      return v[PROJ_W-1] || (v > hi);
   endfunction

endpackage

// File: rtl/lorenz_point_streamer_point_fifo.sv
// point_fifo: synchronous FIFO of point_t with a registered head entry.
// Build option: LORENZ_STREAMER_DROP_CNT_EN enables the saturating drop counter.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write request (dropped when full unless popping)
//   pop             : consumer ready; head leaves when head_valid && pop
//   head, head_valid: registered head entry and its valid flag
//   drop_cnt        : number of pushes refused while full
module point_fifo
   import lorenz_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  point_t      push_data,
   input  logic        pop,
   output point_t      head,
   output logic        head_valid,
   output logic [15:0] drop_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   point_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic             full_c;
   logic             do_pop_c;
   logic             do_push_c;
   logic [PTR_W-1:0] rd_nxt_c;
   logic [CNT_W-1:0] count_d_c;

   // Push is accepted when not full, or when a pop frees the slot this cycle
   always_comb begin
      full_c    = (count == CNT_W'(DEPTH));
      do_pop_c  = pop && (count != '0);
      do_push_c = push && (!full_c || do_pop_c);
      rd_nxt_c  = rd_ptr + PTR_W'(1);
      count_d_c = count;
      if (do_push_c && !do_pop_c) begin
         count_d_c = count + CNT_W'(1);
      end else if (!do_push_c && do_pop_c) begin
         count_d_c = count - CNT_W'(1);
      end
   end

   // Storage array; control state alone defines which entries are live
   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers, occupancy and registered head
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         head       <= '0;
         head_valid <= 1'b0;
      end else begin
         if (do_push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop_c) begin
            rd_ptr <= rd_nxt_c;
         end
         count      <= count_d_c;
         head_valid <= (count_d_c != '0);
         // Head follows the entry at the read pointer; a push into an empty
         // (or emptying) FIFO is forwarded straight into the head register.
         if (do_pop_c) begin
            if (count == CNT_W'(1)) begin
               if (do_push_c) begin
                  head <= push_data;
               end
            end else begin
               head <= mem[rd_nxt_c];
            end
         end else if ((count == '0) && do_push_c) begin
            head <= push_data;
         end
      end
   end

`ifdef LORENZ_STREAMER_DROP_CNT_EN
   logic drop_c;

   assign drop_c = push && !do_push_c;

   // Saturating count of refused pushes
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (drop_c && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`else
   assign drop_cnt = 16'd0;
`endif

endmodule

// File: rtl/lorenz_point_streamer.sv
// lorenz_point_streamer: samples Lorenz solver x/z on step strobes, decimates,
// projects onto a clamped 640x480 raster and queues points for the frame
// buffer writer. Halts permanently (until reset) on the first solver fault.
// Build option: LORENZ_STREAMER_DROP_CNT_EN enables drop_cnt counting.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enable              : level, allows capture (IDLE <-> RUN)
//   step_valid          : solver state strobe
//   xnew, znew          : solver state, signed 7.20
//   overflow            : solver fault flags, any bit set halts the stream
//   pt_valid, pt_ready  : point handshake towards the frame buffer writer
//   pt_x, pt_y, pt_clip : head point and its clamp flag
//   halted              : sticky fault indicator
//   drop_cnt            : points lost to a full FIFO
module lorenz_point_streamer
   import lorenz_pkg::*;
#(
   parameter int unsigned DECIM      = 16,
   parameter int unsigned SHIFT      = 18,
   parameter int unsigned X_OFF      = 320,
   parameter int unsigned Y_OFF      = 400,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      step_valid,
   input  logic signed [STATE_W-1:0] xnew,
   input  logic signed [STATE_W-1:0] znew,
   input  logic [OVF_W-1:0]          overflow,
   output logic                      pt_valid,
   input  logic                      pt_ready,
   output logic [PX_W-1:0]           pt_x,
   output logic [PY_W-1:0]           pt_y,
   output logic                      pt_clip,
   output logic                      halted,
   output logic [15:0]               drop_cnt
);

   stream_state_e state_q;
   stream_state_e state_d;

   logic [DEC_W-1:0]         dec_q;
   logic                     s1_valid;
   logic signed [PROJ_W-1:0] s1_x;
   logic signed [PROJ_W-1:0] s1_z;
   logic                     s2_valid;
   point_t                   s2_pt;
   point_t                   head;

   logic                     accept_c;
   logic                     fault_c;
   logic                     keep_c;
   logic signed [PROJ_W-1:0] px_c;
   logic signed [PROJ_W-1:0] py_c;
   logic                     clip_x_c;
   logic                     clip_y_c;
   point_t                   proj_c;

   // Next-state and step qualification
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      fault_c  = 1'b0;
      keep_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            fault_c  = step_valid && (overflow != '0);
            accept_c = step_valid && (overflow == '0);
            keep_c   = accept_c && (dec_q == DEC_W'(DECIM - 1));
            // A fault wins over a simultaneous enable drop
            if (fault_c) begin
               state_d = ST_HALT;
            end else if (!enable) begin
               state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register, sticky halt flag and decimation counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         halted  <= 1'b0;
         dec_q   <= '0;
      end else begin
         state_q <= state_d;
         halted  <= (state_d == ST_HALT);
         // Counter only moves on accepted steps, so it holds across IDLE
         if (accept_c) begin
            dec_q <= keep_c ? '0 : dec_q + DEC_W'(1);
         end
      end
   end

   // Stage 1: capture shifted state of the kept step
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_z     <= '0;
      end else begin
         s1_valid <= keep_c;
         if (keep_c) begin
            s1_x <= PROJ_W'(xnew >>> SHIFT);
            s1_z <= PROJ_W'(znew >>> SHIFT);
         end
      end
   end

   // Offset and clamp to the raster; y grows downward so z is subtracted
   always_comb begin
      px_c     = s1_x + $signed(PROJ_W'(X_OFF));
      py_c     = $signed(PROJ_W'(Y_OFF)) - s1_z;
      clip_x_c = out_of_range(px_c, $signed(PROJ_W'(SCREEN_W - 1)));
      clip_y_c = out_of_range(py_c, $signed(PROJ_W'(SCREEN_H - 1)));
      proj_c   = '0;
      if (px_c[PROJ_W-1]) begin
         proj_c.x = '0;
      end else if (clip_x_c) begin
         proj_c.x = PX_W'(SCREEN_W - 1);
      end else begin
         proj_c.x = PX_W'(px_c);
      end
      if (py_c[PROJ_W-1]) begin
         proj_c.y = '0;
      end else if (clip_y_c) begin
         proj_c.y = PY_W'(SCREEN_H - 1);
      end else begin
         proj_c.y = PY_W'(py_c);
      end
      proj_c.clip = clip_x_c || clip_y_c;
   end

   // Stage 2: registered projected point, pushed into the FIFO next edge
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_pt    <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_pt <= proj_c;
         end
      end
   end

   point_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (s2_valid),
      .push_data  (s2_pt),
      .pop        (pt_ready),
      .head       (head),
      .head_valid (pt_valid),
      .drop_cnt   (drop_cnt)
   );

   assign pt_x    = head.x;
   assign pt_y    = head.y;
   assign pt_clip = head.clip;

endmodule

// File: tb/tb_lorenz_point_streamer.sv
// Directed self-checking bench for lorenz_point_streamer.
// dut_a: DECIM=1, SHIFT=18 (latency, clamping, backpressure, fault, reset).
// dut_b: DECIM=4, SHIFT=16 (decimation and x-axis clamping), always ready.
module tb_lorenz_point_streamer;
   import lorenz_pkg::*;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic               reset;
   logic               enable;
   logic               step_valid;
   logic signed [26:0] xnew;
   logic signed [26:0] znew;
   logic [8:0]         overflow;

   logic               a_ready;
   logic               a_valid;
   logic [9:0]         a_x;
   logic [8:0]         a_y;
   logic               a_clip;
   logic               a_halted;
   logic [15:0]        a_drop;

   logic               b_ready;
   logic               b_valid;
   logic [9:0]         b_x;
   logic [8:0]         b_y;
   logic               b_clip;
   logic               b_halted;
   logic [15:0]        b_drop;

   int vecs  = 0;
   int fails = 0;

   point_t qa[$];
   point_t qb[$];

   lorenz_point_streamer #(
      .DECIM (1), .SHIFT (18), .X_OFF (320), .Y_OFF (400), .FIFO_DEPTH (16)
   ) dut_a (
      .clk (clk), .reset (reset), .enable (enable), .step_valid (step_valid),
      .xnew (xnew), .znew (znew), .overflow (overflow),
      .pt_valid (a_valid), .pt_ready (a_ready), .pt_x (a_x), .pt_y (a_y),
      .pt_clip (a_clip), .halted (a_halted), .drop_cnt (a_drop)
   );

   lorenz_point_streamer #(
      .DECIM (4), .SHIFT (16), .X_OFF (320), .Y_OFF (400), .FIFO_DEPTH (16)
   ) dut_b (
      .clk (clk), .reset (reset), .enable (enable), .step_valid (step_valid),
      .xnew (xnew), .znew (znew), .overflow (overflow),
      .pt_valid (b_valid), .pt_ready (b_ready), .pt_x (b_x), .pt_y (b_y),
      .pt_clip (b_clip), .halted (b_halted), .drop_cnt (b_drop)
   );

   // Record every accepted handshake (pre-edge values)
   always @(posedge clk) begin
      if (a_valid && a_ready) qa.push_back({a_x, a_y, a_clip});
      if (b_valid && b_ready) qb.push_back({b_x, b_y, b_clip});
   end

   function automatic logic signed [26:0] fx(input int v);
      return 27'(v * 1048576);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic signed [26:0] x, input logic signed [26:0] z,
                       input logic [8:0] ov);
      xnew       = x;
      znew       = z;
      overflow   = ov;
      step_valid = 1'b1;
      tick();
      step_valid = 1'b0;
      overflow   = 9'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      step_valid = 1'b0;
      xnew       = '0;
      znew       = '0;
      overflow   = '0;
      a_ready    = 1'b0;
      b_ready    = 1'b1;

      // Reset state
      do_reset();
      chk("rst_valid", 32'(a_valid), 0);
      chk("rst_x", 32'(a_x), 0);
      chk("rst_y", 32'(a_y), 0);
      chk("rst_clip", 32'(a_clip), 0);
      chk("rst_halted", 32'(a_halted), 0);
      chk("rst_drop", 32'(a_drop), 0);
      chk("rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));

      // Latency: x=0, z=20.0 -> (320,320)
      enable  = 1'b1;
      a_ready = 1'b1;
      tick();
      step(fx(0), fx(20), 9'd0);
      chk("lat_n0", 32'(a_valid), 0);
      tick();
      chk("lat_n1", 32'(a_valid), 0);
      tick();
      chk("lat_valid", 32'(a_valid), 1);
      chk("lat_x", 32'(a_x), 320);
      chk("lat_y", 32'(a_y), 320);
      chk("lat_clip", 32'(a_clip), 0);
      tick();

      // y clamps high: x=-63.0 -> 68, z=-30.0 -> 520 -> 479
      step(fx(-63), fx(-30), 9'd0);
      tick(); tick();
      chk("yclip_x", 32'(a_x), 68);
      chk("yclip_y", 32'(a_y), 479);
      chk("yclip_clip", 32'(a_clip), 1);
      tick();

      // In range near the top: x=63.0 -> 572, z=63.0 -> 148
      step(fx(63), fx(63), 9'd0);
      tick(); tick();
      chk("top_x", 32'(a_x), 572);
      chk("top_y", 32'(a_y), 148);
      chk("top_clip", 32'(a_clip), 0);
      tick();

      // Boundary: shifted z=-79 -> 479 unclamped, -80 -> 480 clamped
      step(fx(0), 27'(-79 * 262144), 9'd0);
      tick(); tick();
      chk("edge479_y", 32'(a_y), 479);
      chk("edge479_clip", 32'(a_clip), 0);
      tick();
      step(fx(0), 27'(-80 * 262144), 9'd0);
      tick(); tick();
      chk("edge480_y", 32'(a_y), 479);
      chk("edge480_clip", 32'(a_clip), 1);
      tick();

      // Decimation on dut_b: 16 steps keep steps 4, 8, 12, 16
      do_reset();
      tick();
      qb.delete();
      for (int k = 1; k <= 16; k++) step(27'(k * 65536), fx(0), 9'd0);
      repeat (5) tick();
      chk("dec_count", 32'(qb.size()), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < qb.size()) begin
            chk("dec_x", 32'(qb[i].x), 32'(320 + 4 * (i + 1)));
            chk("dec_y", 32'(qb[i].y), 400);
         end
      end

      // x clamping on dut_b: -40.0 -> -320 -> 0, +40.0 -> 960 -> 639
      qb.delete();
      repeat (4) step(fx(-40), fx(0), 9'd0);
      repeat (4) step(fx(40), fx(0), 9'd0);
      repeat (5) tick();
      chk("xclip_count", 32'(qb.size()), 2);
      if (qb.size() >= 2) begin
         chk("xclip_lo_x", 32'(qb[0].x), 0);
         chk("xclip_lo_clip", 32'(qb[0].clip), 1);
         chk("xclip_hi_x", 32'(qb[1].x), 639);
         chk("xclip_hi_clip", 32'(qb[1].clip), 1);
      end

      // Backpressure: 20 steps with ready low, 16 held, 4 dropped
      do_reset();
      tick();
      a_ready = 1'b0;
      for (int k = 1; k <= 20; k++) step(27'(k * 262144), fx(0), 9'd0);
      repeat (3) tick();
      chk("bp_valid", 32'(a_valid), 1);
      chk("bp_head", 32'(a_x), 321);
`ifdef LORENZ_STREAMER_DROP_CNT_EN
      chk("bp_drop", 32'(a_drop), 4);
`else
      chk("bp_drop", 32'(a_drop), 0);
`endif
      tick();
      chk("bp_stable", 32'(a_x), 321);
      qa.delete();
      a_ready = 1'b1;
      repeat (20) tick();
      chk("bp_drained", 32'(qa.size()), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < qa.size()) chk("bp_order", 32'(qa[i].x), 32'(321 + i));
      end

      // Fault on step 5: steps 1..4 drain, nothing after
      do_reset();
      tick();
      qa.delete();
      for (int k = 1; k <= 4; k++) step(27'(k * 262144), fx(0), 9'd0);
      chk("flt_pre", 32'(a_halted), 0);
      step(27'(5 * 262144), fx(0), 9'h004);
      chk("flt_halted", 32'(a_halted), 1);
      for (int k = 6; k <= 8; k++) step(27'(k * 262144), fx(0), 9'd0);
      repeat (6) tick();
      chk("flt_count", 32'(qa.size()), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < qa.size()) chk("flt_x", 32'(qa[i].x), 32'(321 + i));
      end
      chk("flt_sticky", 32'(a_halted), 1);
      chk("flt_state", 32'(dut_a.state_q), 32'(ST_HALT));
      do_reset();
      chk("flt_cleared", 32'(a_halted), 0);

      // Reset with 8 points queued and one in stage 2
      tick();
      a_ready = 1'b0;
      for (int k = 1; k <= 9; k++) step(27'(k * 262144), fx(0), 9'd0);
      tick();
      chk("mid_valid", 32'(a_valid), 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(a_valid), 0);
      chk("mid_rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
      reset = 1'b0;
      qa.delete();
      a_ready = 1'b1;
      repeat (6) tick();
      chk("mid_no_stale", 32'(qa.size()), 0);
      chk("mid_empty", 32'(a_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
